bit_sync_filter: RTL and testbench
==================================

// Module: bit_sync_filter
// PURPOSE
//  Multi-channel CDC synchronizer for quasi-static control/status bits from other clock domains.
//  Per channel: NUM_STAGES-flop synchronizer, then a glitch filter with stability counter.
//  Emits filtered level SYNC, plus one-cycle rise/fall pulses and a change flag in the Sync_clk domain.
//  Next-generation replacement for the plain bit synchronizer, used in front of the SYS_CTRL / register file.
// PARAMETERS
//  BUS_WIDTH   4  number of independent channels (>=1)
//  NUM_STAGES  2  synchronizer flops per channel (>=2)
//  FILT_CNT    3  consecutive differing cycles required to update SYNC (>=1; 1 = no filtering)
//  CNT_W       localparam = $clog2(FILT_CNT+1), width of per-channel counter
// PORTS
//  Sync_clk    in   1          destination-domain clock
//  Reg_reset   in   1          reset, asynchronous, active-low
//  ASYNCH      in   BUS_WIDTH  asynchronous input bits
//  FILT_EN     in   1          filter enable, synchronous to Sync_clk; 0 = bypass (behaves as FILT_CNT=1)
//  SYNC        out  BUS_WIDTH  synchronized, filtered level
//  RISE_PULSE  out  BUS_WIDTH  1-cycle pulse per channel on SYNC 0->1
//  FALL_PULSE  out  BUS_WIDTH  1-cycle pulse per channel on SYNC 1->0
//  CHG_ANY     out  1          OR-reduce of RISE_PULSE|FALL_PULSE, registered
// BEHAVIOUR
//  Reset (Reg_reset=0, async): all sync flops, counters, SYNC, RISE_PULSE, FALL_PULSE, CHG_ANY = 0.
//  Sync chain: ASYNCH -> stage1 -> ... -> stageNUM_STAGES = raw[ch]. Plain shift, no logic between stages.
//  Filter, per channel, evaluated on every posedge Sync_clk:
//   - raw == SYNC                          : cnt <= 0, SYNC holds.
//   - raw != SYNC, cnt == EFF-1            : SYNC <= raw, cnt <= 0.
//   - raw != SYNC, otherwise               : cnt <= cnt+1.
//   - EFF = FILT_CNT when FILT_EN=1; EFF = 1 when FILT_EN=0. When FILT_EN=0, cnt is held at 0.
//  Latency, ASYNCH change to SYNC change (ASYNCH stable):
//   - NUM_STAGES+FILT_CNT edges when filtering.
//   - NUM_STAGES+1 edges in bypass.
//  Glitch rejection: a raw pulse shorter than EFF cycles never reaches SYNC and produces no pulse.
//   - Counter restarts at 0 whenever raw returns to SYNC, so flicker never accumulates.
//  Pulses are registered at the same edge SYNC updates and are high exactly 1 cycle:
//   - RISE_PULSE[ch] <= next_SYNC[ch] & ~SYNC[ch]
//   - FALL_PULSE[ch] <= ~next_SYNC[ch] & SYNC[ch]
//   - CHG_ANY <= |(rise|fall) and asserts in the same cycle as the pulses.
//   - In bypass, SYNC can change every cycle; RISE and FALL then alternate and are never both high on a channel.
//  Channels are fully independent. Simultaneous events on several channels set several pulse bits in the same cycle.
//  FILT_EN 1->0 mid-count: cnt clears; if raw still differs, SYNC updates on the next edge.
//  FILT_EN 0->1: counting starts from 0.
//  Reset mid-operation: immediate clear, no pulse generated by the reset itself.
//   - After release, an ASYNCH bit held at 1 yields a normal RISE_PULSE after the full latency.
//  Counter never exceeds FILT_CNT-1; no wrap-around is possible.
// TESTING  (BUS_WIDTH=4, NUM_STAGES=2, FILT_CNT=3 unless noted)
//  1. Reg_reset=0 with ASYNCH=4'hF -> SYNC=0, all pulses 0.
//     Release -> SYNC=4'hF at 5th edge; RISE_PULSE=4'hF and CHG_ANY=1 for exactly 1 cycle.
//  2. FILT_EN=1, ASYNCH[0] high for 2 cycles -> SYNC[0]=0, no pulses.
//     High for 3+ cycles -> SYNC[0]=1 at edge 5 after the rise, RISE_PULSE=4'b0001 for 1 cycle.
//  3. FILT_EN=0, ASYNCH[1] toggles every 4 cycles -> SYNC[1] follows 3 edges later.
//     Alternating 1-cycle RISE_PULSE[1] / FALL_PULSE[1].
//  4. ch0 0->1 and ch2 1->0 in the same cycle -> same cycle: RISE_PULSE=4'b0001, FALL_PULSE=4'b0100, CHG_ANY=1.
//  5. Reg_reset asserted while ch3 cnt=2 -> immediate clear, SYNC=0, no pulse.
//     ASYNCH=0 after release -> outputs stay 0.
//  6. FILT_EN 1->0 while ch0 cnt=1 and raw differs -> SYNC[0] updates on the next edge with a single pulse.

Source files
------------

// File: rtl/bit_sync_filter_if.sv
// Signal bundle between a bit_sync_filter and its user: asynchronous bits and
// filter control in, filtered levels and edge pulses out.
interface bit_sync_filter_if #(
  parameter int BUS_WIDTH = 4
);
  logic [BUS_WIDTH-1:0] ASYNCH;
  logic                 FILT_EN;
  logic [BUS_WIDTH-1:0] SYNC;
  logic [BUS_WIDTH-1:0] RISE_PULSE;
  logic [BUS_WIDTH-1:0] FALL_PULSE;
  logic                 CHG_ANY;

  modport master (
    output ASYNCH, FILT_EN,
    input  SYNC, RISE_PULSE, FALL_PULSE, CHG_ANY
  );

  modport slave (
    input  ASYNCH, FILT_EN,
    output SYNC, RISE_PULSE, FALL_PULSE, CHG_ANY
  );
endinterface

// File: rtl/bit_sync_filter.sv
// Multi-channel synchronizer for quasi-static bits: a plain flop chain per channel
// followed by a stability-counter glitch filter and registered edge pulses.
module bit_sync_filter #(
  parameter int BUS_WIDTH  = 4,
  parameter int NUM_STAGES = 2,
  parameter int FILT_CNT   = 3
) (
  input logic             Sync_clk,
  input logic             Reg_reset,
  bit_sync_filter_if.slave bus
);
  localparam int CNT_W = $clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [BUS_WIDTH-1:0] stage_reg [NUM_STAGES];
  logic [BUS_WIDTH-1:0] raw;
  logic [BUS_WIDTH-1:0] sync_reg;
  logic [BUS_WIDTH-1:0] rise_reg;
  logic [BUS_WIDTH-1:0] fall_reg;
  logic                 chg_reg;
  wire  [BUS_WIDTH-1:0] sync_next;
  logic [BUS_WIDTH-1:0] rise_next;
  logic [BUS_WIDTH-1:0] fall_next;

  always_ff @(posedge Sync_clk or negedge Reg_reset) begin
    if (!Reg_reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= bus.ASYNCH;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign raw = stage_reg[NUM_STAGES-1];

  generate
    for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             differs;
      logic             expire;

      // Bypass forces an immediate update; the counter then never leaves zero.
      assign differs  = raw[gi] ^ sync_reg[gi];
      assign expire   = !bus.FILT_EN || (cnt_reg == CNT_LAST);
      assign sync_next[gi] = (differs && expire) ? raw[gi] : sync_reg[gi];
      assign cnt_next = (differs && !expire) ? cnt_reg + CNT_W'(1) : '0;

      always_ff @(posedge Sync_clk or negedge Reg_reset) begin
        if (!Reg_reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  assign rise_next = sync_next & ~sync_reg;
  assign fall_next = ~sync_next & sync_reg;

  always_ff @(posedge Sync_clk or negedge Reg_reset) begin
    if (!Reg_reset) begin
      sync_reg <= '0;
      rise_reg <= '0;
      fall_reg <= '0;
      chg_reg  <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
      chg_reg  <= |(rise_next | fall_next);
    end
  end

  assign bus.SYNC       = sync_reg;
  assign bus.RISE_PULSE = rise_reg;
  assign bus.FALL_PULSE = fall_reg;
  assign bus.CHG_ANY    = chg_reg;
endmodule

// File: tb/tb_bit_sync_filter.sv
// Directed bench for bit_sync_filter (4 channels, 2 stages, filter count 3);
// expected values are hand-derived edge counts from each input change.
module tb_bit_sync_filter;
  logic Sync_clk = 1'b0;
  logic Reg_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bit_sync_filter_if #(.BUS_WIDTH(4)) bus ();

  bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(2), .FILT_CNT(3)) dut (
    .Sync_clk (Sync_clk),
    .Reg_reset(Reg_reset),
    .bus      (bus)
  );

  always #5 Sync_clk = ~Sync_clk;

  // One active edge, then sample 1 time unit later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Sync_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    bus.ASYNCH = 4'hF;
    bus.FILT_EN = 1'b1;
    Reg_reset = 1'b0;
    tick(3);
    checks++; if (bus.SYNC !== 4'h0) begin errors++; $display("FAIL reset_sync got %h want %h", bus.SYNC, 4'h0); end
    checks++; if (bus.RISE_PULSE !== 4'h0 || bus.FALL_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got rise=%h fall=%h chg=%b want 0", bus.RISE_PULSE, bus.FALL_PULSE, bus.CHG_ANY); end
    Reg_reset = 1'b1;
    tick(4);
    checks++; if (bus.SYNC !== 4'h0) begin errors++; $display("FAIL release_edge4_sync got %h want %h", bus.SYNC, 4'h0); end
    tick(1);
    checks++; if (bus.SYNC !== 4'hF) begin errors++; $display("FAIL release_edge5_sync got %h want %h", bus.SYNC, 4'hF); end
    checks++; if (bus.RISE_PULSE !== 4'hF || bus.CHG_ANY !== 1'b1) begin
      errors++; $display("FAIL release_rise got rise=%h chg=%b want rise=f chg=1", bus.RISE_PULSE, bus.CHG_ANY); end
    tick(1);
    checks++; if (bus.RISE_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0 || bus.SYNC !== 4'hF) begin
      errors++; $display("FAIL release_pulse_end got rise=%h chg=%b sync=%h want 0 0 f", bus.RISE_PULSE, bus.CHG_ANY, bus.SYNC); end
  endtask

  task automatic test_glitch;
    bus.ASYNCH = 4'h0;
    tick(8);
    checks++; if (bus.SYNC !== 4'h0) begin errors++; $display("FAIL glitch_setup got %h want %h", bus.SYNC, 4'h0); end
    bus.ASYNCH = 4'h1;
    tick(2);
    bus.ASYNCH = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++; if (bus.SYNC !== 4'h0 || bus.RISE_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0) begin
        errors++; $display("FAIL glitch_reject cyc%0d got sync=%h rise=%h chg=%b want 0", i, bus.SYNC, bus.RISE_PULSE, bus.CHG_ANY); end
    end
    bus.ASYNCH = 4'h1;
    tick(4);
    checks++; if (bus.SYNC !== 4'h0) begin errors++; $display("FAIL filt_edge4 got %h want %h", bus.SYNC, 4'h0); end
    tick(1);
    checks++; if (bus.SYNC !== 4'h1 || bus.RISE_PULSE !== 4'h1 || bus.CHG_ANY !== 1'b1) begin
      errors++; $display("FAIL filt_edge5 got sync=%h rise=%h chg=%b want 1 1 1", bus.SYNC, bus.RISE_PULSE, bus.CHG_ANY); end
    tick(1);
    checks++; if (bus.RISE_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0) begin
      errors++; $display("FAIL filt_pulse_end got rise=%h chg=%b want 0 0", bus.RISE_PULSE, bus.CHG_ANY); end
  endtask

  task automatic test_bypass;
    logic [3:0] pat;
    logic       v;
    bus.FILT_EN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = (k % 2 == 0);
      pat = {2'b00, v, 1'b1};
      bus.ASYNCH = pat;
      tick(2);
      checks++; if (bus.SYNC[1] !== ~v) begin errors++; $display("FAIL bypass_hold k%0d got %b want %b", k, bus.SYNC[1], ~v); end
      tick(1);
      checks++; if (bus.SYNC !== pat) begin errors++; $display("FAIL bypass_sync k%0d got %h want %h", k, bus.SYNC, pat); end
      checks++; if (bus.RISE_PULSE !== (v ? 4'h2 : 4'h0) || bus.FALL_PULSE !== (v ? 4'h0 : 4'h2) || bus.CHG_ANY !== 1'b1) begin
        errors++; $display("FAIL bypass_pulse k%0d got rise=%h fall=%h chg=%b want v=%b", k, bus.RISE_PULSE, bus.FALL_PULSE, bus.CHG_ANY, v); end
      tick(1);
      checks++; if (bus.RISE_PULSE !== 4'h0 || bus.FALL_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0) begin
        errors++; $display("FAIL bypass_pulse_end k%0d got rise=%h fall=%h chg=%b want 0", k, bus.RISE_PULSE, bus.FALL_PULSE, bus.CHG_ANY); end
    end
  endtask

  task automatic test_simultaneous;
    bus.FILT_EN = 1'b1;
    bus.ASYNCH = 4'h4;
    tick(8);
    checks++; if (bus.SYNC !== 4'h4) begin errors++; $display("FAIL simul_setup got %h want %h", bus.SYNC, 4'h4); end
    bus.ASYNCH = 4'h1;
    tick(4);
    checks++; if (bus.RISE_PULSE !== 4'h0 || bus.FALL_PULSE !== 4'h0 || bus.SYNC !== 4'h4) begin
      errors++; $display("FAIL simul_early got sync=%h rise=%h fall=%h want 4 0 0", bus.SYNC, bus.RISE_PULSE, bus.FALL_PULSE); end
    tick(1);
    checks++; if (bus.RISE_PULSE !== 4'h1 || bus.FALL_PULSE !== 4'h4 || bus.CHG_ANY !== 1'b1 || bus.SYNC !== 4'h1) begin
      errors++; $display("FAIL simul_pulses got sync=%h rise=%h fall=%h chg=%b want 1 1 4 1", bus.SYNC, bus.RISE_PULSE, bus.FALL_PULSE, bus.CHG_ANY); end
    tick(1);
    checks++; if (bus.RISE_PULSE !== 4'h0 || bus.FALL_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0) begin
      errors++; $display("FAIL simul_end got rise=%h fall=%h chg=%b want 0", bus.RISE_PULSE, bus.FALL_PULSE, bus.CHG_ANY); end
  endtask

  task automatic test_reset_mid;
    bus.ASYNCH = 4'h9;
    tick(4);
    #2 Reg_reset = 1'b0;
    #1;
    checks++; if (bus.SYNC !== 4'h0 || bus.RISE_PULSE !== 4'h0 || bus.FALL_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0) begin
      errors++; $display("FAIL reset_mid got sync=%h rise=%h fall=%h chg=%b want 0", bus.SYNC, bus.RISE_PULSE, bus.FALL_PULSE, bus.CHG_ANY); end
    bus.ASYNCH = 4'h0;
    tick(2);
    Reg_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++; if (bus.SYNC !== 4'h0 || bus.RISE_PULSE !== 4'h0 || bus.FALL_PULSE !== 4'h0 || bus.CHG_ANY !== 1'b0) begin
        errors++; $display("FAIL reset_quiet cyc%0d got sync=%h rise=%h fall=%h chg=%b want 0", i, bus.SYNC, bus.RISE_PULSE, bus.FALL_PULSE, bus.CHG_ANY); end
    end
  endtask

  task automatic test_filt_switch;
    int rises;
    bus.ASYNCH = 4'h1;
    tick(3);
    checks++; if (bus.SYNC !== 4'h0) begin errors++; $display("FAIL switch_pre got %h want %h", bus.SYNC, 4'h0); end
    bus.FILT_EN = 1'b0;
    tick(1);
    checks++; if (bus.SYNC !== 4'h1 || bus.RISE_PULSE !== 4'h1 || bus.CHG_ANY !== 1'b1) begin
      errors++; $display("FAIL switch_update got sync=%h rise=%h chg=%b want 1 1 1", bus.SYNC, bus.RISE_PULSE, bus.CHG_ANY); end
    rises = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (bus.RISE_PULSE !== 4'h0) rises++;
    end
    checks++; if (rises !== 0) begin errors++; $display("FAIL switch_single got extra=%0d want 0", rises); end
    // Re-enable filtering: a fall must take the full filtered latency.
    bus.FILT_EN = 1'b1;
    bus.ASYNCH = 4'h0;
    tick(4);
    checks++; if (bus.SYNC !== 4'h1) begin errors++; $display("FAIL reenable_edge4 got %h want %h", bus.SYNC, 4'h1); end
    tick(1);
    checks++; if (bus.SYNC !== 4'h0 || bus.FALL_PULSE !== 4'h1) begin
      errors++; $display("FAIL reenable_edge5 got sync=%h fall=%h want 0 1", bus.SYNC, bus.FALL_PULSE); end
  endtask

  initial begin
    bus.ASYNCH = 4'h0;
    bus.FILT_EN = 1'b1;
    test_reset;
    test_glitch;
    test_bypass;
    test_simultaneous;
    test_reset_mid;
    test_filt_switch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
